// File: rtl/music_evt_pkg.sv
// music_evt_pkg: shared types and constants for the music event controller.
//   state_t     : play/pause/over FSM encoding
//   LEVEL_MAX   : level saturation value
//   MAX_ROWS    : largest row count a single clear can report
//   rows_in_range() : true for a legal rows_cleared value (1..MAX_ROWS)
package music_evt_pkg;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    localparam logic [3:0] LEVEL_MAX = 4'd15;
    localparam logic [2:0] MAX_ROWS  = 3'd4;

    function automatic logic rows_in_range(input logic [2:0] rows);
        return (rows != 3'd0) && (rows <= MAX_ROWS);
    endfunction

endpackage

// File: rtl/music_event_ctrl_btn_debounce.sv
// btn_debounce: pause push-button conditioning.
//   Two-flop synchroniser, stability counter and accepted-level register.
//   Emits a one-cycle o_press on every 0->1 change of the accepted level.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_btn          : raw asynchronous button, active-high
//   o_press        : registered one-cycle press strobe
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1048576
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1, r_sync2;
    logic          r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic [CW-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    assign o_press   = r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Counter only advances while the synchronised level disagrees
            // with the accepted one; any agreement restarts the window.
            if (r_sync2 == r_acc) begin
                r_cnt <= '0;
            end else if (w_cnt_nxt == CNT_DONE) begin
                r_cnt   <= '0;
                r_acc   <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/music_event_ctrl.sv
// music_event_ctrl: turns gameplay events into music control levels.
//   Owns pause debouncing, the retriggerable full-row stretcher, the
//   play/pause/over FSM and the lines-to-level counter.
// Build option: define MUSIC_EVT_LEVEL_EN to include the line/level logic;
//   without it o_level is tied to 0 and i_rows_cleared is ignored.
// Ports:
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_rows_cleared[2:0]    : rows removed (1..4), qualified by i_rows_valid
//   i_rows_valid           : one-cycle row-clear strobe
//   i_pause_btn            : raw pause button
//   i_game_over_in         : one-cycle game-over strobe
//   i_restart              : one-cycle new-game strobe
//   o_full_row             : stretched row-clear indication
//   o_music_pause          : high while paused
//   o_music_game_over      : high while in game over
//   o_level[3:0]           : current level
module music_event_ctrl
    import music_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1048576,
    parameter int FULL_ROW_HOLD   = 4096,
    parameter int LINES_PER_LEVEL = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_rows_cleared,
    input  logic       i_rows_valid,
    input  logic       i_pause_btn,
    input  logic       i_game_over_in,
    input  logic       i_restart,
    output logic       o_full_row,
    output logic       o_music_pause,
    output logic       o_music_game_over,
    output logic [3:0] o_level
);

    localparam int HW = $clog2(FULL_ROW_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(FULL_ROW_HOLD);
    localparam logic [7:0]    LPL       = 8'(LINES_PER_LEVEL);

    state_t        r_state;
    logic          r_music_pause;
    logic          r_music_game_over;
    logic [HW-1:0] r_hold_cnt;
    logic          w_press;
    logic          w_accept;
    logic          w_go;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_pause_btn),
        .o_press (w_press)
    );

    // Game over only matters outside OVER; restart overrides everything.
    assign w_go     = i_game_over_in && (r_state != ST_OVER) && !i_restart;
    assign w_accept = i_rows_valid && (r_state == ST_PLAY) && !i_restart && !i_game_over_in;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state           <= ST_PLAY;
            r_music_pause     <= 1'b0;
            r_music_game_over <= 1'b0;
        end else if (i_restart) begin
            r_state           <= ST_PLAY;
            r_music_pause     <= 1'b0;
            r_music_game_over <= 1'b0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (i_game_over_in) begin
                        r_state           <= ST_OVER;
                        r_music_game_over <= 1'b1;
                    end else if (w_press) begin
                        r_state       <= ST_PAUSED;
                        r_music_pause <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (i_game_over_in) begin
                        r_state           <= ST_OVER;
                        r_music_pause     <= 1'b0;
                        r_music_game_over <= 1'b1;
                    end else if (w_press) begin
                        r_state       <= ST_PLAY;
                        r_music_pause <= 1'b0;
                    end
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state           <= ST_PLAY;
                    r_music_pause     <= 1'b0;
                    r_music_game_over <= 1'b0;
                end
            endcase
        end
    end

    // Hold counter keeps draining while paused; only new loads are blocked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_cnt <= '0;
        end else if (i_restart || w_go) begin
            r_hold_cnt <= '0;
        end else if (w_accept) begin
            r_hold_cnt <= HOLD_LOAD;
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - {{(HW-1){1'b0}}, 1'b1};
        end
    end

    assign o_full_row        = (r_hold_cnt != '0);
    assign o_music_pause     = r_music_pause;
    assign o_music_game_over = r_music_game_over;

`ifdef MUSIC_EVT_LEVEL_EN
    logic [7:0] r_line_cnt;
    logic [3:0] r_level;
    logic [7:0] w_sum;

    assign w_sum = r_line_cnt + {5'd0, i_rows_cleared};

    // rows_cleared is at most 4 and LPL at least 5, so one step suffices.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line_cnt <= 8'd0;
            r_level    <= 4'd0;
        end else if (i_restart) begin
            r_line_cnt <= 8'd0;
            r_level    <= 4'd0;
        end else if (w_accept && rows_in_range(i_rows_cleared)) begin
            if (w_sum >= LPL) begin
                r_line_cnt <= w_sum - LPL;
                if (r_level != LEVEL_MAX)
                    r_level <= r_level + 4'd1;
            end else begin
                r_line_cnt <= w_sum;
            end
        end
    end

    assign o_level = r_level;
`else
    logic w_unused_rows;
    assign w_unused_rows = ^{i_rows_cleared, LPL};
    assign o_level       = 4'd0;
`endif

endmodule

// File: tb/tb_music_event_ctrl.sv
module tb_music_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rows_cleared;
    logic       rows_valid;
    logic       pause_btn;
    logic       game_over_in;
    logic       restart;
    logic       full_row;
    logic       music_pause;
    logic       music_game_over;
    logic [3:0] level;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    music_event_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .FULL_ROW_HOLD  (16),
        .LINES_PER_LEVEL(10)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rows_cleared   (rows_cleared),
        .i_rows_valid     (rows_valid),
        .i_pause_btn      (pause_btn),
        .i_game_over_in   (game_over_in),
        .i_restart        (restart),
        .o_full_row       (full_row),
        .o_music_pause    (music_pause),
        .o_music_game_over(music_game_over),
        .o_level          (level)
    );

    typedef struct {
        logic       rv;
        logic [2:0] rows;
        logic [3:0] lvl;
        logic [7:0] line;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [3:0] exp_lvl(input logic [3:0] x);
`ifdef MUSIC_EVT_LEVEL_EN
        return x;
`else
        return x & 4'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [2:0] r);
        rows_cleared = r;
        rows_valid   = 1'b1;
        tick(1);
        rows_valid   = 1'b0;
        rows_cleared = 3'd0;
    endtask

    task automatic chk_line(input string nm, input logic [7:0] exp);
`ifdef MUSIC_EVT_LEVEL_EN
        chk(nm, dut.r_line_cnt, exp);
`else
        if (exp === 8'hxx) $display("unused %s", nm);
`endif
    endtask

    // Hold the button 20 cycles, report edges until music_pause changes
    // (99 if it never does), then release and let the debouncer settle.
    task automatic press_measure(output int lat);
        logic prev;
        prev      = music_pause;
        lat       = 99;
        pause_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (music_pause !== prev && lat == 99) lat = i;
        end
        pause_btn = 1'b0;
        tick(15);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_full_row"}, full_row, 0);
        chk({nm, "_pause"}, music_pause, 0);
        chk({nm, "_over"}, music_game_over, 0);
        chk({nm, "_level"}, level, 0);
    endtask

    initial begin
        int lat;

        tbl[0]  = '{1'b1, 3'd4, 4'd0, 8'd4};
        tbl[1]  = '{1'b1, 3'd0, 4'd0, 8'd4};
        tbl[2]  = '{1'b1, 3'd5, 4'd0, 8'd4};
        tbl[3]  = '{1'b1, 3'd7, 4'd0, 8'd4};
        tbl[4]  = '{1'b0, 3'd3, 4'd0, 8'd4};
        tbl[5]  = '{1'b1, 3'd4, 4'd0, 8'd8};
        tbl[6]  = '{1'b1, 3'd2, 4'd1, 8'd0};
        tbl[7]  = '{1'b1, 3'd1, 4'd1, 8'd1};
        tbl[8]  = '{1'b1, 3'd4, 4'd1, 8'd5};
        tbl[9]  = '{1'b1, 3'd4, 4'd1, 8'd9};
        tbl[10] = '{1'b1, 3'd4, 4'd2, 8'd3};
        tbl[11] = '{1'b1, 3'd3, 4'd2, 8'd6};
        tbl[12] = '{1'b1, 3'd4, 4'd3, 8'd0};

        rst_n        = 1'b0;
        rows_cleared = 3'd0;
        rows_valid   = 1'b0;
        pause_btn    = 1'b0;
        game_over_in = 1'b0;
        restart      = 1'b0;
        tick(3);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        tick(50);
        chk_all_zero("idle");
        chk("idle_state", dut.r_state, 0);

        // Three 4-row clears, 20 cycles apart
        for (int s = 0; s < 3; s++) begin
            strobe(3'd4);
            chk("fr_rise", full_row, 1);
            tick(15);
            chk("fr_last_high", full_row, 1);
            tick(1);
            chk("fr_fall", full_row, 0);
            tick(3);
        end
        chk("lvl_after3", level, exp_lvl(4'd1));
        chk_line("line_after3", 8'd2);

        // Retrigger 10 cycles after a previous strobe
        strobe(3'd1);
        tick(9);
        strobe(3'd1);
        tick(6);
        chk("retrig_extend", full_row, 1);
        tick(9);
        chk("retrig_last_high", full_row, 1);
        tick(1);
        chk("retrig_fall", full_row, 0);
        chk_line("line_retrig", 8'd4);

        // Debounced pause
        press_measure(lat);
        chk("press1_latency", lat, 11);
        chk("paused", music_pause, 1);
        pause_btn = 1'b1;
        tick(5);
        pause_btn = 1'b0;
        tick(20);
        chk("glitch_no_toggle", music_pause, 1);

        strobe(3'd4);
        chk("paused_no_full_row", full_row, 0);
        chk("paused_level", level, exp_lvl(4'd1));
        chk_line("paused_line", 8'd4);

        press_measure(lat);
        chk("press2_latency", lat, 11);
        chk("unpaused", music_pause, 0);

        // Game over while full_row is running
        strobe(3'd4);
        tick(3);
        chk("go_pre_full_row", full_row, 1);
        game_over_in = 1'b1;
        tick(1);
        game_over_in = 1'b0;
        chk("go_full_row", full_row, 0);
        chk("go_over", music_game_over, 1);
        chk("go_pause", music_pause, 0);
        press_measure(lat);
        chk("over_btn_ignored", lat, 99);
        chk("over_still", music_game_over, 1);
        strobe(3'd4);
        chk("over_no_full_row", full_row, 0);
        chk("over_level", level, exp_lvl(4'd1));
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk_all_zero("restart");
        chk_line("restart_line", 8'd0);

        // Level arithmetic table
        for (int i = 0; i < 13; i++) begin
            rows_cleared = tbl[i].rows;
            rows_valid   = tbl[i].rv;
            tick(1);
            rows_valid   = 1'b0;
            rows_cleared = 3'd0;
            chk($sformatf("tbl%0d_level", i), level, exp_lvl(tbl[i].lvl));
            chk_line($sformatf("tbl%0d_line", i), tbl[i].line);
        end

        // Restart from PLAY also clears
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_play_level", level, 0);
        chk("restart_play_full_row", full_row, 0);

        // Saturation
        for (int n = 1; n <= 40; n++) begin
            strobe(3'd4);
            if (n == 37) chk("sat_37", level, exp_lvl(4'd14));
            if (n == 38) chk("sat_38", level, exp_lvl(4'd15));
            if (n == 40) chk("sat_40", level, exp_lvl(4'd15));
        end

        // Asynchronous reset mid-cycle
        strobe(3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        chk_all_zero("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
